// File: rtl/div_seq_pkg.sv
`default_nettype none
//============================================================================
// Package  : div_seq_pkg
// Purpose  : Shared definitions for the sequential divider: FSM state
//            encodings, default operand width and the DIV/DIVU control
//            constants that EX decode drives onto signed_div_i.
// Revision : 1.0 - initial release
//============================================================================
package div_seq_pkg;

    localparam int c_div_width = 32;

    // Value of signed_div_i for each divide flavour
    localparam logic c_op_div  = 1'b1;   // DIV  : two's complement
    localparam logic c_op_divu = 1'b0;   // DIVU : unsigned

    typedef enum logic [1:0] {
        S_FREE   = 2'b00,
        S_BYZERO = 2'b01,
        S_ON     = 2'b10,
        S_END    = 2'b11
    } div_state_t;

endpackage : div_seq_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
//============================================================================
// Module   : div_step
// Purpose  : One radix-2 restoring division iteration (combinational).
//            Shifts {rem,quot} left by one, trial-subtracts the divisor from
//            the widened remainder and keeps the difference when it is
//            non-negative, setting the new quotient bit.
// Ports    : i_partial  {rem,quot} before the step
//            i_divisor  divisor magnitude
//            o_next     {rem,quot} after the step
// Revision : 1.0 - initial release
//============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_partial,
    input  logic [WIDTH-1:0]   i_divisor,
    output logic [2*WIDTH-1:0] o_next
);

    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH-1:0] w_quot_shift;
    logic [WIDTH:0]   w_trial;

    // Remainder is widened by one bit so the shifted value cannot overflow
    // before the trial subtraction.
    assign w_rem_shift  = {i_partial[2*WIDTH-1:WIDTH], i_partial[WIDTH-1]};
    assign w_quot_shift = {i_partial[WIDTH-2:0], 1'b0};
    assign w_trial      = w_rem_shift - {1'b0, i_divisor};

    // rem < divisor always holds, so a kept (restored) remainder fits WIDTH
    // bits and the trial MSB is a clean borrow flag.
    always_comb begin
        if (!w_trial[WIDTH]) begin
            o_next = {w_trial[WIDTH-1:0], w_quot_shift[WIDTH-1:1], 1'b1};
        end else begin
            o_next = {w_rem_shift[WIDTH-1:0], w_quot_shift};
        end
    end

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
//============================================================================
// Module   : div_seq
// Purpose  : Multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
//            Result goes to HI/LO as {remainder, quotient}. Stalls IF..EX
//            while a division is in flight.
// Ports    : clk, rst          clock, synchronous active-high reset
//            signed_div_i      1 = DIV, 0 = DIVU
//            opdata1_i/2_i     dividend / divisor (sampled in FREE only)
//            start_i           held high by EX until ready_o seen
//            annul_i           abort, wins over start_i
//            result_o          {remainder, quotient}, registered
//            ready_o           result valid, registered
//            stall_req_o       combinational pipeline stall request
// Revision : 1.0 - initial release
//============================================================================
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = c_div_width
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_req_o
);

    localparam int                 c_cnt_w    = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH);

    div_state_t           r_state,    w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt,      w_cnt_nxt;
    logic [2*WIDTH-1:0]   r_work,     w_work_nxt;
    logic [WIDTH-1:0]     r_divisor,  w_divisor_nxt;
    logic                 r_neg_quot, w_neg_quot_nxt;
    logic                 r_neg_rem,  w_neg_rem_nxt;
    logic [2*WIDTH-1:0]   r_result,   w_result_nxt;
    logic                 r_ready,    w_ready_nxt;

    logic [2*WIDTH-1:0]   w_step;
    logic [WIDTH-1:0]     w_abs_dvd;
    logic [WIDTH-1:0]     w_abs_dvs;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic                 w_dvd_neg;
    logic                 w_dvs_neg;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_partial (r_work),
        .i_divisor (r_divisor),
        .o_next    (w_step)
    );

    // Magnitudes: negating 0x80..0 yields the same pattern, which is exactly
    // 2^(WIDTH-1) when read as unsigned, so no special case is needed.
    assign w_dvd_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign w_dvs_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign w_abs_dvd = w_dvd_neg ? -opdata1_i : opdata1_i;
    assign w_abs_dvs = w_dvs_neg ? -opdata2_i : opdata2_i;

    // Remainder takes the dividend's sign; quotient is negative when signs
    // differ. -2^31 / -1 wraps naturally to 0x80000000.
    assign w_quot_fix = r_neg_quot ? -r_work[WIDTH-1:0]       : r_work[WIDTH-1:0];
    assign w_rem_fix  = r_neg_rem  ? -r_work[2*WIDTH-1:WIDTH] : r_work[2*WIDTH-1:WIDTH];

    assign stall_req_o = start_i & ~annul_i & (r_state != S_END);
    assign result_o    = r_result;
    assign ready_o     = r_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_work_nxt     = r_work;
        w_divisor_nxt  = r_divisor;
        w_neg_quot_nxt = r_neg_quot;
        w_neg_rem_nxt  = r_neg_rem;
        w_result_nxt   = r_result;
        w_ready_nxt    = r_ready;

        case (r_state)
            S_FREE: begin
                w_ready_nxt  = 1'b0;
                w_result_nxt = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        w_state_nxt = S_BYZERO;
                    end else begin
                        w_work_nxt     = {{WIDTH{1'b0}}, w_abs_dvd};
                        w_divisor_nxt  = w_abs_dvs;
                        w_neg_quot_nxt = w_dvd_neg ^ w_dvs_neg;
                        w_neg_rem_nxt  = w_dvd_neg;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = S_ON;
                    end
                end
            end

            S_BYZERO: begin
                w_result_nxt = '0;
                w_ready_nxt  = 1'b1;
                w_state_nxt  = S_END;
            end

            S_ON: begin
                // A withdrawn start is handled the same as an annul.
                if (annul_i || !start_i) begin
                    w_state_nxt  = S_FREE;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = '0;
                end else if (r_cnt != c_cnt_last) begin
                    w_work_nxt = w_step;
                    w_cnt_nxt  = r_cnt + 1'b1;
                end else begin
                    w_result_nxt = {w_rem_fix, w_quot_fix};
                    w_ready_nxt  = 1'b1;
                    w_state_nxt  = S_END;
                end
            end

            S_END: begin
                if (annul_i || !start_i) begin
                    w_state_nxt  = S_FREE;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = '0;
                end
            end

            default: begin
                w_state_nxt  = S_FREE;
                w_ready_nxt  = 1'b0;
                w_result_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FREE;
            r_cnt      <= '0;
            r_work     <= '0;
            r_divisor  <= '0;
            r_neg_quot <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_work     <= w_work_nxt;
            r_divisor  <= w_divisor_nxt;
            r_neg_quot <= w_neg_quot_nxt;
            r_neg_rem  <= w_neg_rem_nxt;
            r_result   <= w_result_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

endmodule : div_seq
`default_nettype wire
